btn_autorepeat: RTL and testbench
=================================

# btn_autorepeat

Converts one debounced push-button level into single-cycle command pulses, with hold-to-repeat. It sits between the Debouncer outputs and the Ctl inputs for the up/down setting buttons. A short press yields one increment or decrement, and holding the button scrolls the counter value. Other buttons (reset, trigger, set) keep plain edge behaviour and do not use this block.

## Interface
Parameters:
- FIRST_DELAY, default 50_000_000: cycles from the first pulse to the first repeat pulse (500 ms at 100 MHz); legal range 2 to 2^CNT_W-1.
- REPEAT_PERIOD, default 10_000_000: cycles between repeat pulses (100 ms); must be ≥4 and a multiple of 4.
- ACCEL_AFTER, default 8: number of repeat pulses emitted before acceleration starts; used only with the macro; range 1..255.
- CNT_W, default 26: width of the interval counter; must hold max(FIRST_DELAY, REPEAT_PERIOD).

Ports:
- clk, input, 1: system clock, 100 MHz; all logic is on the rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- en, input, 1: enable; when low, the block is forced to IDLE and no pulses are emitted. Ctl drives it high only in the paused states.
- btn, input, 1: debounced button level from the Debouncer, synchronous to clk; 1 = pressed.
- pulse, output, 1: one-cycle command strobe to Ctl (inc or dec).
- held, output, 1: high while the FSM is in PRESS or REPEAT.
- repeating, output, 1: high while the FSM is in REPEAT.

## Operation
- btn_q is a registered copy of btn. A press edge is btn=1 with btn_q=0.
- FSM states are IDLE, PRESS and REPEAT.
  - IDLE → PRESS on a press edge while en=1. Assert pulse and load the counter with FIRST_DELAY-1.
  - PRESS, btn=1: the counter decrements. At 0, assert pulse, go to REPEAT and load the counter with interval-1.
  - REPEAT, btn=1: at counter 0, assert pulse and reload with interval-1.
  - PRESS or REPEAT with btn=0 → IDLE. No pulse is emitted on release.
  - en=0 in any state → IDLE on the next edge. The counter clears and no pulse is emitted.
- The interval is REPEAT_PERIOD.
- A pulse requires a fresh press edge. A button already held when en rises, or when reset releases, produces nothing until it is released and pressed again.
- Outputs are registered. pulse is never high for two consecutive cycles unless the effective interval is 1.

## Timing
- Reset values: state=IDLE, counter=0, repeat count=0, pulse=0, held=0, repeating=0. btn_q resets to 1 so that a held button is not seen as an edge.
- Latency: a press edge sampled at edge k gives pulse high in cycle k+1 (the cycle after edge k). held rises in the same cycle.
- Pulse spacing from the first pulse at t0:
  - first repeat at t0+FIRST_DELAY;
  - later repeats every REPEAT_PERIOD.
- Release sampled at edge r (btn=0): held and repeating are low from cycle r+1.
  - A counter expiry on that same edge is suppressed, because release wins.
- Release and re-press on consecutive cycles is a new press edge and starts again at the first-pulse latency.
- en falling in the same cycle as a counter expiry: no pulse, because en wins.
- reset_n low mid-hold: all outputs are 0 on the next cycle, and btn_q=1 blocks restart until the button is released.

## Configuration
- BTN_REPEAT_ACCEL_EN defined:
  - An 8-bit repeat count increments on every REPEAT-state pulse and saturates at 255. It clears on entry to IDLE.
  - Once the count reaches ACCEL_AFTER, the interval becomes REPEAT_PERIOD>>2.
- Undefined: the repeat count logic is absent and the interval is always REPEAT_PERIOD. ACCEL_AFTER is ignored.

## Test plan
Parameters for all scenarios: FIRST_DELAY=10, REPEAT_PERIOD=8, ACCEL_AFTER=3.
- Short press: btn high for 5 cycles → exactly one pulse, one cycle after the press edge. held is high for 5 cycles and repeating stays 0.
- Hold, macro undefined: btn held 60 cycles, first pulse at t0 → pulses at t0, t0+10, +18, +26, +34, +42, +50, +58. repeating rises at t0+10.
- Hold, with BTN_REPEAT_ACCEL_EN: same stimulus → pulses at t0, +10, +18, +26, then every 2 cycles from +34 until release. Release and re-press → spacing is 10, 8, … again (repeat count cleared).
- Enable gating: btn held while en=0, then en raised → no pulse. Release, then press → normal first pulse.
- Release on expiry: btn drops on the cycle the counter hits 0 at t0+10 → no second pulse and held=0 the next cycle.
- Reset mid-hold: reset_n low for 2 cycles at t0+15 while btn stays 1 → outputs are 0 and no pulses follow. Release, then press → pulse one cycle after the new press edge.

Source files
------------

// File: rtl/btn_autorepeat.sv
// btn_autorepeat: press/hold-to-repeat pulse generator; BTN_REPEAT_ACCEL_EN enables repeat acceleration
module btn_autorepeat #(
  parameter int FIRST_DELAY   = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int ACCEL_AFTER   = 8,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic btn,
  output logic pulse,
  output logic held,
  output logic repeating
);
  typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;
  localparam logic [CNT_W-1:0] FIRST_LD = CNT_W'(FIRST_DELAY - 1);
  localparam logic [CNT_W-1:0] SLOW_LD  = CNT_W'(REPEAT_PERIOD - 1);
  if (FIRST_DELAY < 2 || REPEAT_PERIOD < 4 || REPEAT_PERIOD % 4 != 0 || ACCEL_AFTER < 1 || ACCEL_AFTER > 255)
    begin : g_bad_param
      $error("btn_autorepeat: illegal parameter value");
    end
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, ivl;
  logic btn_q, press, drop, fire, pulse_n;
  assign press = btn & ~btn_q;
  assign drop  = ~en | (state != IDLE & ~btn);
  assign fire  = ~drop & state != IDLE & cnt == '0;
`ifdef BTN_REPEAT_ACCEL_EN
  localparam logic [CNT_W-1:0] FAST_LD = CNT_W'((REPEAT_PERIOD >> 2) - 1);
  logic [7:0] rcnt, rcnt_n;
  assign ivl = (rcnt >= 8'(ACCEL_AFTER)) ? FAST_LD : SLOW_LD;
  // repeat count: counts repeat pulses, saturates, clears whenever the hold ends
  always_comb begin
    rcnt_n = drop ? 8'd0 : (fire && rcnt != 8'hff) ? rcnt + 8'd1 : rcnt;
  end
  // repeat count register
  always_ff @(posedge clk) begin
    if (!reset_n) rcnt <= '0;
    else rcnt <= rcnt_n;
  end
`else
  assign ivl = SLOW_LD;
`endif
  // next state: release and disable win over any counter expiry
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pulse_n = 1'b0;
    if (drop) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == IDLE) begin
      if (press) begin
        state_n = PRESS;
        cnt_n   = FIRST_LD;
        pulse_n = 1'b1;
      end
    end else if (fire) begin
      state_n = REPEAT;
      cnt_n   = ivl;
      pulse_n = 1'b1;
    end else begin
      cnt_n = cnt - 1'b1;
    end
  end
  // state, counter and registered outputs; btn_q resets high so a held button is not an edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_q     <= 1'b1;
      pulse     <= 1'b0;
      held      <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      btn_q     <= btn;
      pulse     <= pulse_n;
      held      <= state_n != IDLE;
      repeating <= state_n == REPEAT;
    end
  end
endmodule

// File: tb/tb_btn_autorepeat.sv
// tb_btn_autorepeat: directed self-checking bench for btn_autorepeat
module tb_btn_autorepeat;
  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, btn = 1'b0;
  logic pulse, held, repeating;
  int cyc = 0;
  int pq[$];
  int n_chk = 0, n_fail = 0;

  btn_autorepeat #(.FIRST_DELAY(10), .REPEAT_PERIOD(8), .ACCEL_AFTER(3), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .btn(btn),
    .pulse(pulse), .held(held), .repeating(repeating)
  );

  always #5 clk = ~clk;
  // cycle index: the cycle following posedge n is cycle n
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pulse) pq.push_back(cyc);

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_idle();
    btn = 1'b0;
    en = 1'b1;
    tick(3);
    pq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; btn = 1'b1;
    tick(3);
    n_chk++;
    if ({pulse, held, repeating} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 000", {pulse, held, repeating});
    end
    reset_n = 1'b1;
    tick(6);
    n_chk++;
    if (pq.size() != 0 || held !== 1'b0) begin
      n_fail++; $display("FAIL reset_held_btn: pulses %0d held %b want 0 0", pq.size(), held);
    end
    go_idle();
  endtask

  task automatic test_short_press();
    int t0;
    t0 = cyc + 1;
    btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_chk++;
      if (held !== 1'b1 || repeating !== 1'b0) begin
        n_fail++; $display("FAIL short_held[%0d]: held %b rep %b want 1 0", i, held, repeating);
      end
    end
    btn = 1'b0;
    tick(1);
    n_chk++;
    if (held !== 1'b0) begin
      n_fail++; $display("FAIL short_release: held %b want 0", held);
    end
    tick(12);
    n_chk++;
    if (pq.size() != 1 || pq[0] != t0) begin
      n_fail++; $display("FAIL short_pulses: count %0d first %0d want 1 at %0d", pq.size(), pq.size() ? pq[0] : -1, t0);
    end
    go_idle();
  endtask

  task automatic test_hold();
    int t0;
    int ex[$];
    ex.push_back(0);
`ifdef BTN_REPEAT_ACCEL_EN
    ex.push_back(10); ex.push_back(18); ex.push_back(26);
    for (int i = 0; i < 13; i++) ex.push_back(34 + 2 * i);
`else
    for (int i = 0; i < 7; i++) ex.push_back(10 + 8 * i);
`endif
    t0 = cyc + 1;
    btn = 1'b1;
    tick(10);
    n_chk++;
    if (repeating !== 1'b0) begin
      n_fail++; $display("FAIL hold_rep_early: got %b want 0", repeating);
    end
    tick(1);
    n_chk++;
    if (repeating !== 1'b1) begin
      n_fail++; $display("FAIL hold_rep_rise: got %b want 1", repeating);
    end
    tick(49);
    btn = 1'b0;
    tick(1);
    n_chk++;
    if ({held, repeating} !== 2'b00) begin
      n_fail++; $display("FAIL hold_release: got %b want 00", {held, repeating});
    end
    tick(10);
    n_chk++;
    if (pq.size() != ex.size()) begin
      n_fail++; $display("FAIL hold_count: got %0d want %0d", pq.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < pq.size(); i++) begin
      n_chk++;
      if (pq[i] - t0 != ex[i]) begin
        n_fail++; $display("FAIL hold_pulse[%0d]: got t0+%0d want t0+%0d", i, pq[i] - t0, ex[i]);
      end
    end
    go_idle();
    t0 = cyc + 1;
    btn = 1'b1;
    tick(20);
    btn = 1'b0;
    tick(5);
    n_chk++;
    if (pq.size() != 3 || pq[0] != t0 || pq[1] != t0 + 10 || pq[2] != t0 + 18) begin
      n_fail++; $display("FAIL hold_repress: count %0d want pulses at t0,+10,+18", pq.size());
    end
    go_idle();
  endtask

  task automatic test_enable();
    int t0;
    en = 1'b0;
    btn = 1'b1;
    tick(3);
    en = 1'b1;
    tick(15);
    n_chk++;
    if (pq.size() != 0 || held !== 1'b0) begin
      n_fail++; $display("FAIL en_gated: pulses %0d held %b want 0 0", pq.size(), held);
    end
    btn = 1'b0;
    tick(2);
    t0 = cyc + 1;
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(3);
    n_chk++;
    if (pq.size() != 1 || pq[0] != t0) begin
      n_fail++; $display("FAIL en_repress: count %0d want 1 at %0d", pq.size(), t0);
    end
    go_idle();
    t0 = cyc + 1;
    btn = 1'b1;
    tick(10);
    en = 1'b0;
    tick(1);
    n_chk++;
    if ({pulse, held} !== 2'b00) begin
      n_fail++; $display("FAIL en_on_expiry: pulse/held %b want 00", {pulse, held});
    end
    en = 1'b1;
    tick(12);
    n_chk++;
    if (pq.size() != 1 || pq[0] != t0) begin
      n_fail++; $display("FAIL en_on_expiry_count: got %0d want 1", pq.size());
    end
    go_idle();
  endtask

  task automatic test_release_on_expiry();
    int t0;
    t0 = cyc + 1;
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(1);
    n_chk++;
    if ({pulse, held} !== 2'b00) begin
      n_fail++; $display("FAIL rel_expiry: pulse/held %b want 00", {pulse, held});
    end
    tick(10);
    n_chk++;
    if (pq.size() != 1 || pq[0] != t0) begin
      n_fail++; $display("FAIL rel_expiry_count: got %0d want 1", pq.size());
    end
    go_idle();
  endtask

  task automatic test_reset_mid_hold();
    int t0;
    t0 = cyc + 1;
    btn = 1'b1;
    tick(16);
    reset_n = 1'b0;
    tick(1);
    n_chk++;
    if ({pulse, held, repeating} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b want 000", {pulse, held, repeating});
    end
    tick(1);
    reset_n = 1'b1;
    tick(25);
    n_chk++;
    if (pq.size() != 2 || pq[0] != t0 || pq[1] != t0 + 10 || held !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_pulses: count %0d held %b want 2 0", pq.size(), held);
    end
    btn = 1'b0;
    tick(2);
    pq.delete();
    t0 = cyc + 1;
    btn = 1'b1;
    tick(1);
    n_chk++;
    if ({pulse, held} !== 2'b11 || cyc != t0) begin
      n_fail++; $display("FAIL rst_repress: pulse/held %b want 11", {pulse, held});
    end
    btn = 1'b0;
    tick(3);
    n_chk++;
    if (pq.size() != 1) begin
      n_fail++; $display("FAIL rst_repress_count: got %0d want 1", pq.size());
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_hold();
    test_enable();
    test_release_on_expiry();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
